// File: rtl/dsi_ctrl_pkg.sv
// rtl/dsi_ctrl_pkg.sv - shared encodings for the DSI packet stream arbiter
package dsi_ctrl_pkg;

  localparam int AVL_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_VID  = 2'd1,
    ST_CMD  = 2'd2
  } state_t;

  // Grant codes share the state encoding so the output mux can key off the state directly
  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_VID  = 2'd1;
  localparam logic [1:0] GNT_CMD  = 2'd2;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {7'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/dsi_stream_arbiter.sv
// rtl/dsi_stream_arbiter.sv - packet-boundary scheduler between video and command streams
module dsi_stream_arbiter
  import dsi_ctrl_pkg::*;
#(
  parameter int MAX_CMD_BURST = 4,
  parameter int CNT_W         = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ctrl_enable,
  input  logic [AVL_DATA_W-1:0] vid_avl_st_data,
  input  logic                  vid_avl_st_valid,
  input  logic                  vid_avl_st_startofpacket,
  input  logic                  vid_avl_st_endofpacket,
  output logic                  vid_avl_st_ready,
  input  logic [AVL_DATA_W-1:0] cmd_avl_st_data,
  input  logic                  cmd_avl_st_valid,
  input  logic                  cmd_avl_st_startofpacket,
  input  logic                  cmd_avl_st_endofpacket,
  output logic                  cmd_avl_st_ready,
  output logic [AVL_DATA_W-1:0] out_avl_st_data,
  output logic                  out_avl_st_valid,
  output logic                  out_avl_st_startofpacket,
  output logic                  out_avl_st_endofpacket,
  input  logic                  out_avl_st_ready,
  output logic                  out_is_cmd,
  output logic                  busy,
  output logic [CNT_W-1:0]      frame_cnt,
  output logic [7:0]            drop_cnt
);

  localparam logic [3:0] BURST_MAX = 4'(MAX_CMD_BURST);

  state_t     state, state_nxt;
  logic [3:0] burst_cnt, burst_nxt;
  logic [1:0] gnt;
  logic       vid_sop_pend, cmd_sop_pend;
  logic       vid_drop, cmd_drop;
  logic       vid_eop_acc;

  assign gnt = state;

  always_comb begin
    vid_sop_pend = vid_avl_st_valid & vid_avl_st_startofpacket;
    cmd_sop_pend = cmd_avl_st_valid & cmd_avl_st_startofpacket;
    // Beats arriving in IDLE without SOP are orphans of an abandoned packet
    vid_drop     = (state == ST_IDLE) & vid_avl_st_valid & ~vid_avl_st_startofpacket;
    cmd_drop     = (state == ST_IDLE) & cmd_avl_st_valid & ~cmd_avl_st_startofpacket;
    vid_eop_acc  = (state == ST_VID) & vid_avl_st_valid & out_avl_st_ready
                   & vid_avl_st_endofpacket;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      burst_cnt <= 4'd0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    burst_nxt = burst_cnt;
    case (state)
      ST_IDLE: begin
        if (ctrl_enable) begin
          if (cmd_sop_pend && ((burst_cnt < BURST_MAX) || !vid_sop_pend)) begin
            state_nxt = ST_CMD;
            // The burst limit only matters while video is actually waiting
            if (!vid_sop_pend)
              burst_nxt = 4'd1;
            else if (burst_cnt < BURST_MAX)
              burst_nxt = burst_cnt + 4'd1;
          end else if (vid_sop_pend) begin
            state_nxt = ST_VID;
            burst_nxt = 4'd0;
          end
        end
      end
      ST_VID: begin
        if (vid_avl_st_valid && out_avl_st_ready && vid_avl_st_endofpacket)
          state_nxt = ST_IDLE;
      end
      ST_CMD: begin
        if (cmd_avl_st_valid && out_avl_st_ready && cmd_avl_st_endofpacket)
          state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    out_avl_st_data          = '0;
    out_avl_st_valid         = 1'b0;
    out_avl_st_startofpacket = 1'b0;
    out_avl_st_endofpacket   = 1'b0;
    vid_avl_st_ready         = 1'b0;
    cmd_avl_st_ready         = 1'b0;
    out_is_cmd               = 1'b0;
    busy                     = 1'b0;
    // All handshakes are suppressed while reset is held
    if (rst_n) begin
      busy = (state != ST_IDLE);
      case (gnt)
        GNT_VID: begin
          out_avl_st_valid         = vid_avl_st_valid;
          out_avl_st_data          = vid_avl_st_valid ? vid_avl_st_data : '0;
          out_avl_st_startofpacket = vid_avl_st_valid & vid_avl_st_startofpacket;
          out_avl_st_endofpacket   = vid_avl_st_valid & vid_avl_st_endofpacket;
          vid_avl_st_ready         = out_avl_st_ready;
        end
        GNT_CMD: begin
          out_avl_st_valid         = cmd_avl_st_valid;
          out_avl_st_data          = cmd_avl_st_valid ? cmd_avl_st_data : '0;
          out_avl_st_startofpacket = cmd_avl_st_valid & cmd_avl_st_startofpacket;
          out_avl_st_endofpacket   = cmd_avl_st_valid & cmd_avl_st_endofpacket;
          cmd_avl_st_ready         = out_avl_st_ready;
          out_is_cmd               = 1'b1;
        end
        default: begin
          vid_avl_st_ready = vid_drop;
          cmd_avl_st_ready = cmd_drop;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      drop_cnt  <= 8'd0;
    end else begin
      if (vid_eop_acc)
        frame_cnt <= frame_cnt + CNT_W'(1);
      drop_cnt <= sat_add8(drop_cnt, {1'b0, vid_drop} + {1'b0, cmd_drop});
    end
  end

endmodule

// File: doc/dsi_stream_arbiter.md
Name: dsi_stream_arbiter

Overview:
Packet-level scheduler between the packed 32-bit video pixel stream and the DCS/command packet stream. Both feed the single DSI packet assembler input.
- Video packets are whole frames, SOP to EOP.
- Command packets are short LP/HS command bursts.
- Grants are made only at packet boundaries, so a packet is never interleaved with the other stream.
- Commands have priority, bounded by a starvation limit. Video frame starts can be gated by an enable.

Parameters:
MAX_CMD_BURST, 4, max consecutive command packets granted while a video SOP is pending (legal range 1..15)
CNT_W, 16, width of the frame counter

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
ctrl_enable  in  1  1 = new packets may be granted; 0 = finish current packet, then hold in IDLE
vid_avl_st_data  in  32  video source data
vid_avl_st_valid  in  1  video valid
vid_avl_st_startofpacket  in  1  video SOP (frame start)
vid_avl_st_endofpacket  in  1  video EOP (frame end)
vid_avl_st_ready  out  1  video ready
cmd_avl_st_data  in  32  command source data
cmd_avl_st_valid  in  1  command valid
cmd_avl_st_startofpacket  in  1  command SOP
cmd_avl_st_endofpacket  in  1  command EOP
cmd_avl_st_ready  out  1  command ready
out_avl_st_data  out  32  granted source data, 0 when out valid=0
out_avl_st_valid  out  1  output valid
out_avl_st_startofpacket  out  1  output SOP, 0 when out valid=0
out_avl_st_endofpacket  out  1  output EOP, 0 when out valid=0
out_avl_st_ready  in  1  downstream ready
out_is_cmd  out  1  1 while the command stream is granted
busy  out  1  state != IDLE
frame_cnt  out  CNT_W  video EOPs forwarded, wraps
drop_cnt  out  8  beats discarded for missing SOP, saturates at 255

Behaviour:
- Reset is synchronous. On rst_n=0 at a clk edge:
  - state=IDLE, cmd_burst_cnt=0, frame_cnt=0, drop_cnt=0.
  - Every output is 0.
  - Reset mid-packet abandons the packet with no EOP emitted. Upstream is responsible for resync.
- States:
  - IDLE: no grant. out valid=0, out_is_cmd=0.
  - VID: video granted.
  - CMD: command granted.
- Arbitration happens in IDLE only, when ctrl_enable=1. The grant is registered, so there is a 1-cycle bubble between packets.
  - cmd valid & SOP, and (cmd_burst_cnt < MAX_CMD_BURST or no video valid & SOP) -> CMD.
  - Otherwise, video valid & SOP -> VID.
  - Otherwise stay in IDLE.
- In IDLE, both source readys are 0, except for the drop case below.
- Drop rule:
  - In IDLE, a source with valid=1 and SOP=0 gets ready=1 that cycle. The beat is discarded and drop_cnt increments (saturating).
  - If both sources drop in the same cycle, drop_cnt increments by 2, still saturating.
  - A source that is dropping is not considered for a grant that cycle.
- VID/CMD pass-through, with zero added latency:
  - out valid, data, SOP and EOP = granted source signals (combinational mux).
  - granted ready = out_avl_st_ready; the other ready = 0.
  - A beat is accepted when valid & ready.
  - Accepting a beat with EOP=1 returns to IDLE at the next edge. A single-beat packet (SOP & EOP) is legal.
  - A SOP seen mid-packet is forwarded unchanged; no check is made.
- ctrl_enable=0 mid-packet: the current packet completes, then the block stays in IDLE. The drop rule still applies in IDLE.
- cmd_burst_cnt:
  - +1 on each CMD grant, saturating at MAX_CMD_BURST.
  - Cleared to 0 on a VID grant.
  - Cleared to 0 on a CMD grant made while no video SOP is pending; it is then set to 1 for that grant.
- frame_cnt increments, with wrap, on acceptance of a video beat with EOP.
- Output registers must not create a combinational loop from out ready to any input valid.

Decomposition:
- Shared package dsi_ctrl_pkg:
  - state encodings ST_IDLE=2'd0, ST_VID=2'd1, ST_CMD=2'd2.
  - grant code constants.
  - AVL_DATA_W=32.
- No sub-module; a single module with one FSM process, counters and an output mux.

Test Plan:
1. Only video: 3-beat frame with SOP on beat 0 and EOP on beat 2, out ready=1 -> grant after 1 bubble cycle; 3 output beats matching data; frame_cnt=1; back in IDLE the cycle after EOP.
2. Both SOP valid in IDLE, MAX_CMD_BURST=2, cmd supplies 4 single-beat packets, video frame pending -> order cmd, cmd, vid frame, cmd, cmd; out_is_cmd tracks the grant.
3. Video beat valid without SOP (data 0xDEADBEEF) in IDLE -> vid ready=1 for 1 cycle; output not valid; drop_cnt=1; 300 such beats -> drop_cnt=255.
4. Backpressure: out ready toggles 1010 during a 4-beat cmd packet -> no beat lost or duplicated; the video ready stays 0 throughout.
5. ctrl_enable deasserted at beat 2 of a 5-beat video frame -> all 5 beats forwarded; then IDLE with no grant, even with cmd SOP valid; a grant occurs 1 cycle after re-enable.
6. rst_n=0 for one edge mid-CMD packet -> the next cycle has state IDLE, all outputs 0 and counters 0; a fresh SOP is granted normally.
